// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: FSM state encoding and the MEM->WB bus layout.
// WB and ID decode the buses with the same offsets.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } mem_state_e;

    localparam int EX_BUS_W      = 3;
    localparam int ID_BUS_W      = 39;
    localparam int WB_BUS_W      = 72;

    // MEM->WB bus field offsets
    localparam int WB_ERTN_BIT   = 0;
    localparam int WB_EXCEP_BIT  = 1;
    localparam int WB_WDATA_LSB  = 2;
    localparam int WB_WADDR_LSB  = 34;
    localparam int WB_WE_BIT     = 39;
    localparam int WB_PC_LSB     = 40;

    // Pack the MEM->WB bus in the agreed field order.
    function automatic logic [WB_BUS_W-1:0] pack_wb_bus(
        input logic [31:0] pc,
        input logic        rf_we,
        input logic [4:0]  rf_waddr,
        input logic [31:0] wdata,
        input logic        excep_en,
        input logic        ertn_flush
    );
        return {pc, rf_we, rf_waddr, wdata, excep_en, ertn_flush};
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: shift the response word down by the byte offset, then
// sign- or zero-extend to the requested width.
module mem_stage_load_align (
    input  logic [31:0] src,
    input  logic [1:0]  addr_lo,
    input  logic        ld_b,
    input  logic        ld_h,
    input  logic        ld_u,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic        sign_b;
    logic        sign_h;

    // Byte-lane shift followed by width select and extension
    always_comb begin
        shifted = src >> {addr_lo, 3'b000};
        sign_b  = ~ld_u & shifted[7];
        sign_h  = ~ld_u & shifted[15];
        if (ld_b) begin
            result = {{24{sign_b}}, shifted[7:0]};
        end else if (ld_h) begin
            result = {{16{sign_h}}, shifted[15:0]};
        end else begin
            result = shifted;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response of the instruction it
// holds, aligns load data, forwards the writeback value to ID and hands the
// result to WB. Responses still owed at a flush are counted and swallowed.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    output logic                mem_allowin,
    input  logic                ex_to_mem_valid,
    input  logic [31:0]         ex_pc,
    input  logic                ex_mem_req,
    input  logic                ex_res_from_mem,
    input  logic                ex_rf_we,
    input  logic [4:0]          ex_rf_waddr,
    input  logic [31:0]         ex_alu_result,
    input  logic [1:0]          ex_addr_lo,
    input  logic                ex_ld_b,
    input  logic                ex_ld_h,
    input  logic                ex_ld_u,
    input  logic                ex_excep_en,
    input  logic                ex_ertn_flush,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    output logic [EX_BUS_W-1:0] mem_to_ex_bus,
    output logic [ID_BUS_W-1:0] mem_to_id_bus,
    input  logic                wb_allowin,
    output logic                mem_to_wb_valid,
    output logic [WB_BUS_W-1:0] mem_to_wb_bus
);

    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    mem_state_e       state_reg, state_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic             mem_valid_reg;

    logic [31:0]      pc_reg;
    logic             req_reg;
    logic             res_from_mem_reg;
    logic             rf_we_reg;
    logic [4:0]       rf_waddr_reg;
    logic [31:0]      alu_result_reg;
    logic [1:0]       addr_lo_reg;
    logic             ld_b_reg;
    logic             ld_h_reg;
    logic             ld_u_reg;
    logic             excep_en_reg;
    logic             ertn_flush_reg;
    logic [31:0]      rbuf_reg;

    logic             accept;
    logic             drop_zero;
    logic             resp_ok;
    logic             drop_inc;
    logic             drop_dec;
    logic             ready_go;
    logic             rbuf_load;
    logic             use_rbuf;
    logic             stall_ld;
    logic [31:0]      load_src;
    logic [31:0]      load_data;
    logic [31:0]      wdata;

    assign accept    = ex_to_mem_valid & mem_allowin;
    assign drop_zero = (drop_cnt_reg == '0);
    // A response only belongs to the current instruction once all stale ones are gone
    assign resp_ok   = data_sram_data_ok & drop_zero;
    assign drop_dec  = data_sram_data_ok & ~drop_zero;
    // Flushing a request still in flight leaves one more response to discard
    assign drop_inc  = flush & (state_reg == WAIT) & ~resp_ok;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: flush wins, then a newly accepted request, then response/hold handling
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else if (accept && ex_mem_req) begin
            state_next = WAIT;
        end else begin
            case (state_reg)
                WAIT:    if (resp_ok) state_next = wb_allowin ? IDLE : HOLD;
                HOLD:    if (wb_allowin) state_next = IDLE;
                default: ;
            endcase
        end
    end

    // FSM outputs: completion, buffering of a response WB cannot take yet, buffer select
    always_comb begin
        ready_go  = 1'b0;
        rbuf_load = 1'b0;
        use_rbuf  = 1'b0;
        case (state_reg)
            IDLE: ready_go = ~req_reg;
            WAIT: begin
                ready_go  = resp_ok;
                rbuf_load = resp_ok & ~wb_allowin;
            end
            HOLD: begin
                ready_go = 1'b1;
                use_rbuf = 1'b1;
            end
            default: ;
        endcase
    end

    // Outstanding-response counter next value; saturates at MAX_OUTSTANDING
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (drop_inc && !drop_dec) begin
            if (drop_cnt_reg != CNT_MAX) begin
                drop_cnt_next = drop_cnt_reg + CNT_W'(1);
            end
        end else if (drop_dec && !drop_inc) begin
            drop_cnt_next = drop_cnt_reg - CNT_W'(1);
        end
    end

    // Drop counter register; survives flushes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt_reg <= '0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Valid bit and payload capture from EX
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_reg    <= 1'b0;
            pc_reg           <= '0;
            req_reg          <= 1'b0;
            res_from_mem_reg <= 1'b0;
            rf_we_reg        <= 1'b0;
            rf_waddr_reg     <= '0;
            alu_result_reg   <= '0;
            addr_lo_reg      <= '0;
            ld_b_reg         <= 1'b0;
            ld_h_reg         <= 1'b0;
            ld_u_reg         <= 1'b0;
            excep_en_reg     <= 1'b0;
            ertn_flush_reg   <= 1'b0;
        end else begin
            if (flush) begin
                mem_valid_reg <= 1'b0;
            end else if (mem_allowin) begin
                mem_valid_reg <= ex_to_mem_valid;
            end
            if (accept) begin
                pc_reg           <= ex_pc;
                req_reg          <= ex_mem_req;
                res_from_mem_reg <= ex_res_from_mem;
                rf_we_reg        <= ex_rf_we;
                rf_waddr_reg     <= ex_rf_waddr;
                alu_result_reg   <= ex_alu_result;
                addr_lo_reg      <= ex_addr_lo;
                ld_b_reg         <= ex_ld_b;
                ld_h_reg         <= ex_ld_h;
                ld_u_reg         <= ex_ld_u;
                excep_en_reg     <= ex_excep_en;
                ertn_flush_reg   <= ex_ertn_flush;
            end
        end
    end

    // Response buffer for data WB could not take on arrival
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rbuf_reg <= '0;
        end else if (rbuf_load) begin
            rbuf_reg <= data_sram_rdata;
        end
    end

    // The counter must never need to exceed its maximum
    assert property (@(posedge clk) disable iff (!resetn)
        !(drop_inc && !drop_dec && drop_cnt_reg == CNT_MAX));

    assign load_src = use_rbuf ? rbuf_reg : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .src     (load_src),
        .addr_lo (addr_lo_reg),
        .ld_b    (ld_b_reg),
        .ld_h    (ld_h_reg),
        .ld_u    (ld_u_reg),
        .result  (load_data)
    );

    assign wdata           = res_from_mem_reg ? load_data : alu_result_reg;
    assign stall_ld        = mem_valid_reg & res_from_mem_reg & ~ready_go;
    assign mem_allowin     = ~mem_valid_reg | (ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid_reg & ready_go;
    assign mem_to_ex_bus   = {excep_en_reg, ertn_flush_reg, 1'b0} & {EX_BUS_W{mem_valid_reg}};
    assign mem_to_id_bus   = {stall_ld, rf_we_reg, rf_waddr_reg, wdata} & {ID_BUS_W{mem_valid_reg}};
    assign mem_to_wb_bus   = pack_wb_bus(pc_reg, rf_we_reg, rf_waddr_reg, wdata,
                                         excep_en_reg, ertn_flush_reg);

endmodule
